// File: rtl/riscv_dmem_ctrl.sv
// rtl/riscv_dmem_ctrl.sv - data-memory access controller: pipe/debug arbitration, lane steering, single outstanding bus access
module riscv_dmem_ctrl #(
  parameter int XLEN = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              pipe_req_i,
  input  logic [XLEN-1:0]   pipe_adr_i,
  input  logic              pipe_we_i,
  input  logic [1:0]        pipe_size_i,
  input  logic [XLEN-1:0]   pipe_d_i,
  input  logic              pipe_kill_i,
  output logic              pipe_ack_o,
  output logic              pipe_err_o,
  output logic              pipe_misaligned_o,
  output logic [XLEN-1:0]   pipe_q_o,
  input  logic              dbg_req_i,
  input  logic [XLEN-1:0]   dbg_adr_i,
  input  logic              dbg_we_i,
  input  logic [XLEN-1:0]   dbg_d_i,
  output logic              dbg_ack_o,
  output logic              dbg_err_o,
  output logic [XLEN-1:0]   dbg_q_o,
  output logic              bus_req_o,
  output logic [XLEN-1:0]   bus_adr_o,
  output logic              bus_we_o,
  output logic [XLEN/8-1:0] bus_be_o,
  output logic [XLEN-1:0]   bus_d_o,
  input  logic              bus_gnt_i,
  input  logic              bus_ack_i,
  input  logic              bus_err_i,
  input  logic [XLEN-1:0]   bus_q_i
);
  localparam int BW   = XLEN / 8;
  localparam int LSBW = $clog2(BW);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DRAIN} state_e;
  typedef enum logic {OWN_PIPE, OWN_DBG} owner_e;

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d, last_q, last_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic [XLEN-1:0]   bus_adr_q, bus_adr_d;
  logic [XLEN-1:0]   bus_d_q, bus_d_d;
  logic [BW-1:0]     bus_be_q, bus_be_d;

  logic              misalign, pipe_valid, grant_pipe, resp, kill_own;
  logic [LSBW-1:0]   pipe_lane, dbg_lane;
  logic [BW-1:0]     pipe_base_be, pipe_be, dbg_be;
  logic [XLEN-1:0]   pipe_wdata, dbg_wdata;

  always_comb begin
    case (pipe_size_i)
      2'd0:    misalign = 1'b0;
      2'd1:    misalign = pipe_adr_i[0];
      2'd2:    misalign = |pipe_adr_i[1:0];
      default: misalign = |pipe_adr_i[2:0];
    endcase
  end

  assign pipe_misaligned_o = pipe_req_i & ~pipe_kill_i & misalign;
  assign pipe_valid        = pipe_req_i & ~pipe_kill_i & ~misalign;
  // Pipeline wins unless debug is waiting and the pipeline owned the bus last.
  assign grant_pipe        = pipe_valid & (~dbg_req_i | (last_q == OWN_DBG));
  assign resp              = bus_ack_i | bus_err_i;
  assign kill_own          = (owner_q == OWN_PIPE) & pipe_kill_i;

  assign pipe_lane    = pipe_adr_i[LSBW-1:0];
  assign dbg_lane     = dbg_adr_i[LSBW-1:0];
  assign pipe_base_be = BW'((16'd1 << (4'd1 << pipe_size_i)) - 16'd1);
  assign pipe_be      = pipe_base_be << pipe_lane;
  assign dbg_be       = BW'(4'hF) << dbg_lane;
  assign pipe_wdata   = pipe_d_i << {pipe_lane, 3'b000};
  assign dbg_wdata    = dbg_d_i << {dbg_lane, 3'b000};

  assign pipe_q_o  = bus_q_i;
  assign dbg_q_o   = bus_q_i;
  assign bus_req_o = bus_req_q;
  assign bus_adr_o = bus_adr_q;
  assign bus_we_o  = bus_we_q;
  assign bus_be_o  = bus_be_q;
  assign bus_d_o   = bus_d_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      owner_q   <= OWN_PIPE;
      last_q    <= OWN_DBG;
      bus_req_q <= 1'b0;
      bus_we_q  <= 1'b0;
      bus_adr_q <= '0;
      bus_be_q  <= '0;
      bus_d_q   <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      bus_req_q <= bus_req_d;
      bus_we_q  <= bus_we_d;
      bus_adr_q <= bus_adr_d;
      bus_be_q  <= bus_be_d;
      bus_d_q   <= bus_d_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    bus_req_d  = bus_req_q;
    bus_we_d   = bus_we_q;
    bus_adr_d  = bus_adr_q;
    bus_be_d   = bus_be_q;
    bus_d_d    = bus_d_q;
    pipe_ack_o = 1'b0;
    pipe_err_o = 1'b0;
    dbg_ack_o  = 1'b0;
    dbg_err_o  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pipe_valid || dbg_req_i) begin
          if (grant_pipe) begin
            owner_d   = OWN_PIPE;
            bus_adr_d = pipe_adr_i;
            bus_we_d  = pipe_we_i;
            bus_be_d  = pipe_be;
            bus_d_d   = pipe_wdata;
          end else begin
            owner_d   = OWN_DBG;
            bus_adr_d = dbg_adr_i;
            bus_we_d  = dbg_we_i;
            bus_be_d  = dbg_be;
            bus_d_d   = dbg_wdata;
          end
          last_d    = grant_pipe ? OWN_PIPE : OWN_DBG;
          bus_req_d = 1'b1;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        if (kill_own) begin
          bus_req_d = 1'b0;
          state_d   = bus_gnt_i ? DRAIN : IDLE;
        end else if (bus_gnt_i) begin
          bus_req_d = 1'b0;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (kill_own) begin
          state_d = resp ? IDLE : DRAIN;
        end else if (resp) begin
          state_d = IDLE;
          if (owner_q == OWN_PIPE) begin
            pipe_ack_o = bus_ack_i;
            pipe_err_o = bus_err_i;
          end else begin
            dbg_ack_o = bus_ack_i;
            dbg_err_o = bus_err_i;
          end
        end
      end
      default: begin
        if (resp) state_d = IDLE;
      end
    endcase
  end

`ifndef SYNTHESIS
  a_pipe_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
    pipe_req_i && !pipe_kill_i && !pipe_ack_o && !pipe_err_o && !pipe_misaligned_o |=> pipe_req_i);
  a_dbg_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
    dbg_req_i && !dbg_ack_o && !dbg_err_o |=> dbg_req_i);
  a_ack_state: assert property (@(posedge clk_i) disable iff (!rst_ni)
    bus_ack_i |-> (state_q == WAIT || state_q == DRAIN));
  a_ack_err: assert property (@(posedge clk_i) disable iff (!rst_ni) !(bus_ack_i && bus_err_i));
  a_size: assert property (@(posedge clk_i) disable iff (!rst_ni)
    pipe_req_i |-> !(XLEN == 32 && pipe_size_i == 2'd3));
`endif
endmodule

// File: tb/tb_riscv_dmem_ctrl.sv
// tb/tb_riscv_dmem_ctrl.sv - scoreboard bench for riscv_dmem_ctrl
module tb_riscv_dmem_ctrl;
  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        pipe_req_i = 1'b0, pipe_we_i = 1'b0, pipe_kill_i = 1'b0;
  logic [1:0]  pipe_size_i = 2'd0;
  logic [31:0] pipe_adr_i = '0, pipe_d_i = '0;
  logic        pipe_ack_o, pipe_err_o, pipe_misaligned_o;
  logic [31:0] pipe_q_o;
  logic        dbg_req_i = 1'b0, dbg_we_i = 1'b0;
  logic [31:0] dbg_adr_i = '0, dbg_d_i = '0;
  logic        dbg_ack_o, dbg_err_o;
  logic [31:0] dbg_q_o;
  logic        bus_req_o, bus_we_o;
  logic [31:0] bus_adr_o, bus_d_o;
  logic [3:0]  bus_be_o;
  logic        bus_gnt_i = 1'b0, bus_ack_i = 1'b0, bus_err_i = 1'b0;
  logic [31:0] bus_q_i = '0;

  riscv_dmem_ctrl #(.XLEN(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .pipe_req_i(pipe_req_i), .pipe_adr_i(pipe_adr_i), .pipe_we_i(pipe_we_i),
    .pipe_size_i(pipe_size_i), .pipe_d_i(pipe_d_i), .pipe_kill_i(pipe_kill_i),
    .pipe_ack_o(pipe_ack_o), .pipe_err_o(pipe_err_o),
    .pipe_misaligned_o(pipe_misaligned_o), .pipe_q_o(pipe_q_o),
    .dbg_req_i(dbg_req_i), .dbg_adr_i(dbg_adr_i), .dbg_we_i(dbg_we_i), .dbg_d_i(dbg_d_i),
    .dbg_ack_o(dbg_ack_o), .dbg_err_o(dbg_err_o), .dbg_q_o(dbg_q_o),
    .bus_req_o(bus_req_o), .bus_adr_o(bus_adr_o), .bus_we_o(bus_we_o),
    .bus_be_o(bus_be_o), .bus_d_o(bus_d_o), .bus_gnt_i(bus_gnt_i),
    .bus_ack_i(bus_ack_i), .bus_err_i(bus_err_i), .bus_q_i(bus_q_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] adr; logic we; logic [3:0] be; logic [31:0] d;
    bit dbg; bit err; logic [31:0] q;
  } exp_t;

  typedef struct {
    logic [31:0] adr; logic we; logic [3:0] be; logic [31:0] d;
    int lat; logic early; logic pack, perr, dack, derr; logic [31:0] pq, dq;
  } obs_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Acts as the bus slave for one transaction and records what the DUT did.
  task automatic serve_bus(input int ack_dly, input bit err, input logic [31:0] q,
                           output bit tmo, output obs_t o);
    o = '{default: '0};
    tmo = 1'b0;
    @(negedge clk_i);
    while (bus_req_o !== 1'b1 && o.lat < 20) begin
      @(posedge clk_i); #1;
      @(negedge clk_i);
      o.lat++;
    end
    if (bus_req_o !== 1'b1) begin
      tmo = 1'b1;
      return;
    end
    o.adr = bus_adr_o; o.we = bus_we_o; o.be = bus_be_o; o.d = bus_d_o;
    o.early = pipe_ack_o | pipe_err_o | dbg_ack_o | dbg_err_o;
    bus_gnt_i = 1'b1;
    @(posedge clk_i); #1;
    bus_gnt_i = 1'b0;
    repeat (ack_dly) begin
      @(negedge clk_i);
      o.early = o.early | pipe_ack_o | pipe_err_o | dbg_ack_o | dbg_err_o;
      @(posedge clk_i); #1;
    end
    bus_ack_i = !err; bus_err_i = err; bus_q_i = q;
    @(negedge clk_i);
    o.pack = pipe_ack_o; o.perr = pipe_err_o; o.dack = dbg_ack_o; o.derr = dbg_err_o;
    o.pq = pipe_q_o; o.dq = dbg_q_o;
    @(posedge clk_i); #1;
    bus_ack_i = 1'b0; bus_err_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    #3;
    checks++; if (bus_req_o !== 1'b0) begin errors++; $display("FAIL reset_bus_req got=%b exp=0", bus_req_o); end
    checks++; if ({bus_we_o, bus_be_o, bus_adr_o, bus_d_o} !== '0) begin errors++; $display("FAIL reset_bus_fields got we=%b be=%h adr=%h d=%h exp all 0", bus_we_o, bus_be_o, bus_adr_o, bus_d_o); end
    checks++; if ({pipe_ack_o, pipe_err_o, pipe_misaligned_o, dbg_ack_o, dbg_err_o} !== 5'b0) begin errors++; $display("FAIL reset_resp got=%b exp=00000", {pipe_ack_o, pipe_err_o, pipe_misaligned_o, dbg_ack_o, dbg_err_o}); end
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
  endtask

  task automatic test_aligned_load();
    exp_t e; obs_t o; bit tmo;
    pipe_adr_i = 32'h104; pipe_size_i = 2'd2; pipe_we_i = 1'b0; pipe_d_i = '0; pipe_req_i = 1'b1;
    sb.push_back('{adr: 32'h104, we: 1'b0, be: 4'hF, d: 32'h0, dbg: 1'b0, err: 1'b0, q: 32'hDEADBEEF});
    serve_bus(1, 1'b0, 32'hDEADBEEF, tmo, o);
    pipe_req_i = 1'b0;
    e = sb.pop_front();
    checks++; if (tmo) begin errors++; $display("FAIL lw_timeout got=no bus_req exp=bus_req"); end
    checks++; if (o.lat !== 1) begin errors++; $display("FAIL lw_latency got=%0d exp=1", o.lat); end
    checks++; if (o.adr !== e.adr || o.be !== e.be || o.we !== e.we) begin errors++; $display("FAIL lw_bus got adr=%h be=%h we=%b exp adr=%h be=%h we=%b", o.adr, o.be, o.we, e.adr, e.be, e.we); end
    checks++; if (o.early !== 1'b0) begin errors++; $display("FAIL lw_early_ack got=%b exp=0", o.early); end
    checks++; if (o.pack !== 1'b1 || o.perr !== 1'b0 || o.dack !== 1'b0) begin errors++; $display("FAIL lw_resp got ack=%b err=%b dack=%b exp 1 0 0", o.pack, o.perr, o.dack); end
    checks++; if (o.pq !== e.q) begin errors++; $display("FAIL lw_q got=%h exp=%h", o.pq, e.q); end
    @(negedge clk_i);
    checks++; if (pipe_ack_o !== 1'b0) begin errors++; $display("FAIL lw_ack_after got=%b exp=0", pipe_ack_o); end
    @(posedge clk_i); #1;
  endtask

  task automatic test_store_lanes();
    exp_t e; obs_t o; bit tmo;
    logic [31:0] adrs [4];
    logic [1:0]  sizes[4];
    logic [31:0] dats [4];
    logic [3:0]  ebe  [4];
    logic [31:0] ed   [4];
    adrs  = '{32'h203, 32'h102, 32'h201, 32'h300};
    sizes = '{2'd0, 2'd1, 2'd0, 2'd2};
    dats  = '{32'h000000A5, 32'h00001234, 32'h0000005A, 32'hCAFEF00D};
    ebe   = '{4'h8, 4'hC, 4'h2, 4'hF};
    ed    = '{32'hA5000000, 32'h12340000, 32'h00005A00, 32'hCAFEF00D};
    for (int i = 0; i < 4; i++) begin
      pipe_adr_i = adrs[i]; pipe_size_i = sizes[i]; pipe_d_i = dats[i]; pipe_we_i = 1'b1; pipe_req_i = 1'b1;
      sb.push_back('{adr: adrs[i], we: 1'b1, be: ebe[i], d: ed[i], dbg: 1'b0, err: 1'b0, q: 32'h0});
      serve_bus(0, 1'b0, 32'h0, tmo, o);
      pipe_req_i = 1'b0; pipe_we_i = 1'b0;
      e = sb.pop_front();
      checks++; if (tmo) begin errors++; $display("FAIL st%0d_timeout got=no bus_req exp=bus_req", i); end
      checks++; if (o.adr !== e.adr || o.we !== e.we) begin errors++; $display("FAIL st%0d_adr got adr=%h we=%b exp adr=%h we=1", i, o.adr, o.we, e.adr); end
      checks++; if (o.be !== e.be || o.d !== e.d) begin errors++; $display("FAIL st%0d_lanes got be=%h d=%h exp be=%h d=%h", i, o.be, o.d, e.be, e.d); end
      checks++; if (o.pack !== 1'b1) begin errors++; $display("FAIL st%0d_ack got=%b exp=1", i, o.pack); end
    end
  endtask

  task automatic test_misaligned();
    logic [31:0] adrs [4];
    logic [1:0]  sizes[4];
    adrs  = '{32'h101, 32'h102, 32'h103, 32'h106};
    sizes = '{2'd1, 2'd2, 2'd2, 2'd2};
    for (int i = 0; i < 4; i++) begin
      pipe_adr_i = adrs[i]; pipe_size_i = sizes[i]; pipe_we_i = 1'b0; pipe_req_i = 1'b1;
      @(negedge clk_i);
      checks++; if (pipe_misaligned_o !== 1'b1 || bus_req_o !== 1'b0) begin errors++; $display("FAIL mis%0d_flag got mis=%b req=%b exp mis=1 req=0", i, pipe_misaligned_o, bus_req_o); end
      @(posedge clk_i); #1;
      pipe_kill_i = 1'b1;
      @(negedge clk_i);
      checks++; if (bus_req_o !== 1'b0 || pipe_misaligned_o !== 1'b0) begin errors++; $display("FAIL mis%0d_idle_kill got req=%b mis=%b exp 0 0", i, bus_req_o, pipe_misaligned_o); end
      @(posedge clk_i); #1;
      pipe_req_i = 1'b0; pipe_kill_i = 1'b0;
    end
  endtask

  task automatic test_kill();
    exp_t e; obs_t o; bit tmo; logic seen;
    seen = 1'b0;
    pipe_adr_i = 32'h40; pipe_size_i = 2'd2; pipe_we_i = 1'b0; pipe_req_i = 1'b1;
    @(posedge clk_i); #1;
    bus_gnt_i = 1'b1;
    @(negedge clk_i);
    checks++; if (bus_req_o !== 1'b1) begin errors++; $display("FAIL killw_issue got=%b exp=1", bus_req_o); end
    @(posedge clk_i); #1;
    bus_gnt_i = 1'b0; pipe_kill_i = 1'b1;
    @(negedge clk_i); seen = seen | pipe_ack_o | pipe_err_o;
    @(posedge clk_i); #1;
    pipe_kill_i = 1'b0; pipe_req_i = 1'b0;
    @(negedge clk_i); seen = seen | pipe_ack_o | pipe_err_o;
    @(posedge clk_i); #1;
    bus_ack_i = 1'b1; bus_q_i = 32'h11111111;
    @(negedge clk_i); seen = seen | pipe_ack_o | pipe_err_o | dbg_ack_o;
    @(posedge clk_i); #1;
    bus_ack_i = 1'b0;
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL killw_no_report got=%b exp=0", seen); end
    dbg_adr_i = 32'h90; dbg_we_i = 1'b0; dbg_req_i = 1'b1;
    sb.push_back('{adr: 32'h90, we: 1'b0, be: 4'hF, d: 32'h0, dbg: 1'b1, err: 1'b0, q: 32'h22222222});
    serve_bus(0, 1'b0, 32'h22222222, tmo, o);
    dbg_req_i = 1'b0;
    e = sb.pop_front();
    checks++; if (tmo || o.lat !== 1) begin errors++; $display("FAIL killw_idle_after got tmo=%b lat=%0d exp tmo=0 lat=1", tmo, o.lat); end
    checks++; if (o.dack !== 1'b1 || o.dq !== e.q || o.pack !== 1'b0) begin errors++; $display("FAIL killw_dbg got dack=%b dq=%h pack=%b exp 1 %h 0", o.dack, o.dq, o.pack, e.q); end

    pipe_adr_i = 32'h44; pipe_req_i = 1'b1;
    @(posedge clk_i); #1;
    pipe_kill_i = 1'b1;
    @(negedge clk_i);
    checks++; if (bus_req_o !== 1'b1) begin errors++; $display("FAIL killi_issue got=%b exp=1", bus_req_o); end
    @(posedge clk_i); #1;
    pipe_kill_i = 1'b0; pipe_req_i = 1'b0;
    @(negedge clk_i);
    checks++; if (bus_req_o !== 1'b0) begin errors++; $display("FAIL killi_drop got=%b exp=0", bus_req_o); end
    @(posedge clk_i); #1;
    pipe_adr_i = 32'h48; pipe_req_i = 1'b1;
    sb.push_back('{adr: 32'h48, we: 1'b0, be: 4'hF, d: 32'h0, dbg: 1'b0, err: 1'b0, q: 32'h33333333});
    serve_bus(0, 1'b0, 32'h33333333, tmo, o);
    pipe_req_i = 1'b0;
    e = sb.pop_front();
    checks++; if (tmo || o.lat !== 1 || o.adr !== e.adr) begin errors++; $display("FAIL killi_next got tmo=%b lat=%0d adr=%h exp 0 1 %h", tmo, o.lat, o.adr, e.adr); end
    checks++; if (o.pack !== 1'b1 || o.pq !== e.q) begin errors++; $display("FAIL killi_next_ack got ack=%b q=%h exp 1 %h", o.pack, o.pq, e.q); end

    pipe_adr_i = 32'h4C; pipe_req_i = 1'b1;
    @(posedge clk_i); #1;
    bus_gnt_i = 1'b1; pipe_kill_i = 1'b1;
    @(posedge clk_i); #1;
    bus_gnt_i = 1'b0; pipe_kill_i = 1'b0; pipe_req_i = 1'b0; bus_ack_i = 1'b1;
    @(negedge clk_i);
    checks++; if (pipe_ack_o !== 1'b0) begin errors++; $display("FAIL killg_drain got=%b exp=0", pipe_ack_o); end
    @(posedge clk_i); #1;
    bus_ack_i = 1'b0;
    dbg_adr_i = 32'h94; dbg_req_i = 1'b1;
    serve_bus(0, 1'b0, 32'h44444444, tmo, o);
    dbg_req_i = 1'b0;
    checks++; if (tmo || o.lat !== 1 || o.dack !== 1'b1) begin errors++; $display("FAIL killg_idle_after got tmo=%b lat=%0d dack=%b exp 0 1 1", tmo, o.lat, o.dack); end
  endtask

  task automatic test_contention();
    exp_t e; obs_t o; bit tmo;
    logic [31:0] eadr[4];
    bit          edbg[4];
    eadr = '{32'h10, 32'h80, 32'h14, 32'h84};
    edbg = '{1'b0, 1'b1, 1'b0, 1'b1};
    rst_ni = 1'b0;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    pipe_adr_i = 32'h10; pipe_size_i = 2'd2; pipe_we_i = 1'b0; pipe_d_i = '0; pipe_req_i = 1'b1;
    dbg_adr_i = 32'h80; dbg_we_i = 1'b0; dbg_d_i = '0; dbg_req_i = 1'b1;
    for (int r = 0; r < 4; r++) begin
      sb.push_back('{adr: eadr[r], we: (r == 3), be: 4'hF, d: (r == 3) ? 32'h5555AAAA : 32'h0,
                     dbg: edbg[r], err: 1'b0, q: 32'hA0000000 + r});
      serve_bus(0, 1'b0, 32'hA0000000 + r, tmo, o);
      case (r)
        0: pipe_adr_i = 32'h14;
        1: begin dbg_adr_i = 32'h84; dbg_we_i = 1'b1; dbg_d_i = 32'h5555AAAA; end
        2: pipe_req_i = 1'b0;
        default: begin dbg_req_i = 1'b0; dbg_we_i = 1'b0; end
      endcase
      e = sb.pop_front();
      checks++; if (tmo || o.adr !== e.adr) begin errors++; $display("FAIL arb%0d_grant got tmo=%b adr=%h exp adr=%h", r, tmo, o.adr, e.adr); end
      checks++; if (o.be !== e.be || o.we !== e.we || o.d !== e.d) begin errors++; $display("FAIL arb%0d_bus got be=%h we=%b d=%h exp be=%h we=%b d=%h", r, o.be, o.we, o.d, e.be, e.we, e.d); end
      checks++; if (o.dack !== e.dbg || o.pack !== !e.dbg) begin errors++; $display("FAIL arb%0d_owner got pack=%b dack=%b exp dack=%b", r, o.pack, o.dack, e.dbg); end
      checks++; if (o.dq !== e.q || o.pq !== e.q) begin errors++; $display("FAIL arb%0d_q got pq=%h dq=%h exp=%h", r, o.pq, o.dq, e.q); end
    end
  endtask

  task automatic test_error();
    exp_t e; obs_t o; bit tmo;
    pipe_adr_i = 32'h300; pipe_size_i = 2'd2; pipe_we_i = 1'b1; pipe_d_i = 32'h12345678; pipe_req_i = 1'b1;
    sb.push_back('{adr: 32'h300, we: 1'b1, be: 4'hF, d: 32'h12345678, dbg: 1'b0, err: 1'b1, q: 32'h0});
    serve_bus(1, 1'b1, 32'h0, tmo, o);
    pipe_req_i = 1'b0; pipe_we_i = 1'b0;
    e = sb.pop_front();
    checks++; if (tmo || o.d !== e.d || o.we !== e.we) begin errors++; $display("FAIL err_bus got tmo=%b d=%h we=%b exp d=%h we=1", tmo, o.d, o.we, e.d); end
    checks++; if (o.perr !== e.err || o.pack !== 1'b0 || o.derr !== 1'b0) begin errors++; $display("FAIL err_resp got perr=%b pack=%b derr=%b exp 1 0 0", o.perr, o.pack, o.derr); end
    @(negedge clk_i);
    checks++; if (pipe_err_o !== 1'b0) begin errors++; $display("FAIL err_one_cycle got=%b exp=0", pipe_err_o); end
    @(posedge clk_i); #1;
    dbg_adr_i = 32'h98; dbg_req_i = 1'b1;
    serve_bus(0, 1'b0, 32'h55555555, tmo, o);
    dbg_req_i = 1'b0;
    checks++; if (tmo || o.lat !== 1 || o.dack !== 1'b1) begin errors++; $display("FAIL err_idle_after got tmo=%b lat=%0d dack=%b exp 0 1 1", tmo, o.lat, o.dack); end
  endtask

  task automatic test_reset_mid();
    obs_t o; bit tmo;
    pipe_adr_i = 32'h500; pipe_size_i = 2'd2; pipe_we_i = 1'b0; pipe_req_i = 1'b1;
    @(posedge clk_i); #1;
    @(negedge clk_i);
    checks++; if (bus_req_o !== 1'b1) begin errors++; $display("FAIL rstmid_issue got=%b exp=1", bus_req_o); end
    #1 rst_ni = 1'b0;
    #1;
    checks++; if (bus_req_o !== 1'b0 || bus_adr_o !== 32'h0) begin errors++; $display("FAIL rstmid_async got req=%b adr=%h exp 0 0", bus_req_o, bus_adr_o); end
    pipe_req_i = 1'b0;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    pipe_adr_i = 32'h504; pipe_req_i = 1'b1;
    serve_bus(0, 1'b0, 32'h66666666, tmo, o);
    pipe_req_i = 1'b0;
    checks++; if (tmo || o.lat !== 1 || o.adr !== 32'h504 || o.pack !== 1'b1) begin errors++; $display("FAIL rstmid_recover got tmo=%b lat=%0d adr=%h ack=%b exp 0 1 504 1", tmo, o.lat, o.adr, o.pack); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_aligned_load();
    test_store_lanes();
    test_misaligned();
    test_kill();
    test_contention();
    test_error();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
